// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline control chain: stage indices,
// default geometry and control-bundle field offsets.
package pipe_pkg;

    localparam int ST_EX = 0;
    localparam int ST_ME = 1;
    localparam int ST_WB = 2;

    localparam int DEF_STAGES = 3;
    localparam int DEF_WIDTH  = 16;

    // Field layout of the control bundle, LSB first
    localparam int F_MEMTOREG     = 0;
    localparam int F_MEMWRITE     = 1;
    localparam int F_REGWRITE     = 2;
    localparam int F_HIWRITE      = 3;
    localparam int F_LOWRITE      = 4;
    localparam int F_ISMULT       = 5;
    localparam int F_ISDIV        = 6;
    localparam int F_ALUCONTROL   = 7;
    localparam int F_ALUCONTROL_W = 4;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline control register with valid bit.
// Priority: rst > clear > hold > bubble > load; invalid entries carry zero.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (hold) begin
            q       <= q;
            q_valid <= q_valid;
        end else if (bubble) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q       <= d_valid ? d : '0;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Control-bundle carrier from decode to writeback with stall
// back-propagation, bubble insertion, flushes and a bubble counter.
module pipe_ctrl_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    input  logic [STAGES-1:0]       stall_req,
    input  logic [STAGES-1:0]       flush_req,
    input  logic                    excp_flush,
    output logic [STAGES*WIDTH-1:0] out_data,
    output logic [STAGES-1:0]       out_valid,
    output logic [STAGES-1:0]       stall_out,
    output logic                    upstream_stall,
    output logic [CNT_W-1:0]        bubble_cnt
);

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] d;
            logic             d_valid;
            logic             bubble;

            // A stage stalls if it or any older stage is blocked
            assign stall_out[k] = |stall_req[STAGES-1:k];

            if (k == 0) begin : g_head
                assign d       = in_data;
                assign d_valid = in_valid;
                assign bubble  = 1'b0;
            end else begin : g_body
                assign d       = out_data[(k-1)*WIDTH +: WIDTH];
                assign d_valid = out_valid[k-1];
                assign bubble  = stall_out[k-1] & ~stall_out[k];
            end

            pipe_stage_reg #(
                .WIDTH(WIDTH)
            ) u_reg (
                .clk     (clk),
                .rst     (rst),
                .clear   (excp_flush | flush_req[k]),
                .hold    (stall_out[k]),
                .bubble  (bubble),
                .d       (d),
                .d_valid (d_valid),
                .q       (out_data[k*WIDTH +: WIDTH]),
                .q_valid (out_valid[k])
            );
        end
    endgenerate

    assign upstream_stall = stall_out[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid[STAGES-1] && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed self-checking bench for pipe_ctrl_chain (default build plus
// a CNT_W=4 build sharing the same stimulus for saturation).
module tb_pipe_ctrl_chain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  stall_req = '0;
    logic [2:0]  flush_req = '0;
    logic        excp_flush = 1'b0;

    logic [47:0] out_data;
    logic [2:0]  out_valid;
    logic [2:0]  stall_out;
    logic        upstream_stall;
    logic [31:0] bubble_cnt;

    logic [47:0] out_data4;
    logic [2:0]  out_valid4;
    logic [2:0]  stall_out4;
    logic        upstream_stall4;
    logic [3:0]  bubble_cnt4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl_chain dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .stall_req      (stall_req),
        .flush_req      (flush_req),
        .excp_flush     (excp_flush),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .stall_out      (stall_out),
        .upstream_stall (upstream_stall),
        .bubble_cnt     (bubble_cnt)
    );

    pipe_ctrl_chain #(.CNT_W(4)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .stall_req      (stall_req),
        .flush_req      (flush_req),
        .excp_flush     (excp_flush),
        .out_data       (out_data4),
        .out_valid      (out_valid4),
        .stall_out      (stall_out4),
        .upstream_stall (upstream_stall4),
        .bubble_cnt     (bubble_cnt4)
    );

    function automatic logic [15:0] stg(input int k);
        return out_data[k*16 +: 16];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_data    = '0;
        in_valid   = 1'b0;
        stall_req  = '0;
        flush_req  = '0;
        excp_flush = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] req_v [3];
        logic [2:0] exp_v [3];
        req_v = '{3'b010, 3'b100, 3'b001};
        exp_v = '{3'b011, 3'b111, 3'b001};
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data    = 16'($urandom);
            in_valid   = 1'($urandom);
            stall_req  = 3'($urandom);
            flush_req  = 3'($urandom);
            excp_flush = 1'($urandom);
            step();
        end
        tests++;
        if (out_data !== 48'h0) begin
            fails++;
            $display("FAIL reset_data got=%h exp=0", out_data);
        end
        tests++;
        if (out_valid !== 3'b000) begin
            fails++;
            $display("FAIL reset_valid got=%b exp=000", out_valid);
        end
        tests++;
        if (bubble_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            stall_req = req_v[i];
            #1;
            tests++;
            if (stall_out !== exp_v[i] || upstream_stall !== exp_v[i][0]) begin
                fails++;
                $display("FAIL reset_stall req=%b got=%b/%b exp=%b",
                         req_v[i], stall_out, upstream_stall, exp_v[i]);
            end
        end
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_latency();
        logic [15:0] vals [3];
        vals = '{16'h00A1, 16'h00A2, 16'h00A3};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (stg(2) !== vals[i] || out_valid[2] !== 1'b1) begin
                fails++;
                $display("FAIL latency_%0d got=%h/%b exp=%h/1",
                         i, stg(2), out_valid[2], vals[i]);
            end
            step();
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1;
        in_data  = 16'h00A1;
        step();
        in_data  = 16'h00A2;
        step();
        in_valid  = 1'b0;
        in_data   = '0;
        stall_req = 3'b010;
        #1;
        tests++;
        if (stall_out !== 3'b011 || upstream_stall !== 1'b1) begin
            fails++;
            $display("FAIL stall_comb got=%b/%b exp=011/1", stall_out, upstream_stall);
        end
        step();
        tests++;
        if (stg(0) !== 16'h00A2 || stg(1) !== 16'h00A1 || stg(2) !== 16'h0
            || out_valid !== 3'b011) begin
            fails++;
            $display("FAIL stall_hold got=%h valid=%b exp=0000_00a1_00a2 valid=011",
                     out_data, out_valid);
        end
        stall_req = 3'b000;
        step();
        tests++;
        if (stg(2) !== 16'h00A1 || stg(1) !== 16'h00A2 || stg(0) !== 16'h0
            || out_valid !== 3'b110) begin
            fails++;
            $display("FAIL stall_release got=%h valid=%b exp=00a1_00a2_0000 valid=110",
                     out_data, out_valid);
        end
    endtask

    task automatic test_flush_stall();
        in_valid = 1'b1;
        in_data  = 16'h00B5;
        step();
        in_valid  = 1'b0;
        in_data   = '0;
        stall_req = 3'b001;
        flush_req = 3'b001;
        #1;
        tests++;
        if (upstream_stall !== 1'b1) begin
            fails++;
            $display("FAIL flush_stall_up got=%b exp=1", upstream_stall);
        end
        step();
        tests++;
        if (stg(0) !== 16'h0 || out_valid[0] !== 1'b0) begin
            fails++;
            $display("FAIL flush_beats_stall got=%h/%b exp=0/0", stg(0), out_valid[0]);
        end
        tests++;
        if (stg(1) !== 16'h0 || out_valid[1] !== 1'b0) begin
            fails++;
            $display("FAIL flush_bubble got=%h/%b exp=0/0", stg(1), out_valid[1]);
        end
        idle_inputs();
    endtask

    task automatic test_excp();
        in_valid = 1'b1;
        in_data  = 16'h00C1;
        step();
        in_data  = 16'h00C2;
        step();
        in_data  = 16'h00C3;
        step();
        tests++;
        if (out_valid !== 3'b111 || stg(2) !== 16'h00C1) begin
            fails++;
            $display("FAIL excp_fill got=%h valid=%b exp stage2=00c1 valid=111",
                     out_data, out_valid);
        end
        in_data    = 16'h00C4;
        stall_req  = 3'b100;
        excp_flush = 1'b1;
        step();
        tests++;
        if (out_data !== 48'h0 || out_valid !== 3'b000) begin
            fails++;
            $display("FAIL excp_clear got=%h valid=%b exp=0 valid=000",
                     out_data, out_valid);
        end
        stall_req  = 3'b000;
        excp_flush = 1'b0;
        in_data    = 16'h00D1;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        tests++;
        if (stg(0) !== 16'h00D1 || out_valid !== 3'b001) begin
            fails++;
            $display("FAIL excp_resume got=%h valid=%b exp stage0=00d1 valid=001",
                     out_data, out_valid);
        end
        step();
        step();
        tests++;
        if (stg(2) !== 16'h00D1 || out_valid !== 3'b100) begin
            fails++;
            $display("FAIL excp_reach got=%h valid=%b exp stage2=00d1 valid=100",
                     out_data, out_valid);
        end
    endtask

    task automatic test_bubble_cnt();
        idle_inputs();
        rst = 1'b1;
        step();
        tests++;
        if (bubble_cnt !== 32'd0 || bubble_cnt4 !== 4'd0) begin
            fails++;
            $display("FAIL cnt_rst got=%0d/%0d exp=0/0", bubble_cnt, bubble_cnt4);
        end
        rst = 1'b0;
        repeat (5) step();
        tests++;
        if (bubble_cnt !== 32'd5 || bubble_cnt4 !== 4'd5) begin
            fails++;
            $display("FAIL cnt_idle5 got=%0d/%0d exp=5/5", bubble_cnt, bubble_cnt4);
        end
        repeat (10) step();
        tests++;
        if (bubble_cnt4 !== 4'hF) begin
            fails++;
            $display("FAIL cnt_reach_max got=%h exp=f", bubble_cnt4);
        end
        repeat (3) step();
        tests++;
        if (bubble_cnt4 !== 4'hF) begin
            fails++;
            $display("FAIL cnt_saturate got=%h exp=f", bubble_cnt4);
        end
        tests++;
        if (bubble_cnt !== 32'd18) begin
            fails++;
            $display("FAIL cnt_wide got=%0d exp=18", bubble_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_flush_stall();
        test_excp();
        test_bubble_cnt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
